// File: rtl/pc_gen.sv
// -----------------------------------------------------------------------------
// pc_gen -- program-counter generator for the multi-cycle fetch stage.
//
// Selects the next PC from sequential, branch, jump, call/return, exception
// and exception-return sources. A circular return-address stack (RAS) supplies
// return targets and an exception PC register (EPC) supplies the
// exception-return target. All state updates on the falling edge of clk.
//
// Ports:
//   clk        : clock; state updates on the falling edge
//   Rst_n      : asynchronous active-low reset
//   Write_PC   : update enable; when low all state holds
//   PC_s[2:0]  : next-PC select (seq/branch/jump/call/ret/exc/eret/hold)
//   B          : branch target
//   F          : jump, call, or fallback return target
//   PC         : current PC
//   EPC        : saved exception PC
//   ras_empty  : RAS holds no entries
//   ras_full   : RAS holds RAS_DEPTH entries
//   ras_err    : sticky RAS overflow/underflow flag, cleared only by reset
// -----------------------------------------------------------------------------
module pc_gen #(
  parameter int unsigned      WIDTH      = 32,
  parameter logic [WIDTH-1:0] RESET_ADDR = {WIDTH{1'b0}},
  parameter logic [WIDTH-1:0] EXC_VECTOR = WIDTH'(32'h0000_0008),
  parameter int unsigned      RAS_DEPTH  = 4
) (
  input  logic             clk,
  input  logic             Rst_n,
  input  logic             Write_PC,
  input  logic [2:0]       PC_s,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] F,
  output logic [WIDTH-1:0] PC,
  output logic [WIDTH-1:0] EPC,
  output logic             ras_empty,
  output logic             ras_full,
  output logic             ras_err
);

  localparam int unsigned PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(RAS_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1'b1);
  localparam logic [PTR_W-1:0] PTR_ZERO   = {PTR_W{1'b0}};
  localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1'b1);
  localparam logic [WIDTH-1:0] ALIGN_MASK = {{(WIDTH-2){1'b1}}, 2'b00};
  localparam logic [WIDTH-1:0] PC_STEP    = WIDTH'(3'd4);

  localparam logic [2:0] SEL_SEQ  = 3'b000;
  localparam logic [2:0] SEL_BR   = 3'b001;
  localparam logic [2:0] SEL_JMP  = 3'b010;
  localparam logic [2:0] SEL_CALL = 3'b011;
  localparam logic [2:0] SEL_RET  = 3'b100;
  localparam logic [2:0] SEL_EXC  = 3'b101;
  localparam logic [2:0] SEL_ERET = 3'b110;
  localparam logic [2:0] SEL_HOLD = 3'b111;

  // Word-align a target before it is loaded into PC.
  function automatic logic [WIDTH-1:0] align_f(input logic [WIDTH-1:0] addr);
    return addr & ALIGN_MASK;
  endfunction

  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] r_epc;
  logic [PTR_W-1:0] r_top;   // index of the current top-of-stack entry
  logic [CNT_W-1:0] r_cnt;
  logic             r_err;
  logic [WIDTH-1:0] r_ras [RAS_DEPTH];

  logic [WIDTH-1:0] w_pc_inc;
  logic [WIDTH-1:0] w_ras_top;
  logic [WIDTH-1:0] w_pc_nxt;
  logic [WIDTH-1:0] w_epc_nxt;
  logic [PTR_W-1:0] w_top_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_err_nxt;
  logic             w_push;

  // Natural modulo-2^WIDTH wrap gives the silent roll-over to zero.
  assign w_pc_inc  = r_pc + PC_STEP;
  assign w_ras_top = r_ras[r_top];

  // Next-state selection for PC, EPC and the RAS bookkeeping.
  always_comb begin
    w_pc_nxt  = r_pc;
    w_epc_nxt = r_epc;
    w_top_nxt = r_top;
    w_cnt_nxt = r_cnt;
    w_err_nxt = r_err;
    w_push    = 1'b0;
    if (Write_PC) begin
      case (PC_s)
        SEL_SEQ:  w_pc_nxt = w_pc_inc;
        SEL_BR:   w_pc_nxt = align_f(B);
        SEL_JMP:  w_pc_nxt = align_f(F);
        SEL_CALL: begin
          w_pc_nxt  = align_f(F);
          w_push    = 1'b1;
          // The slot after top is the oldest entry when full, so a full
          // push overwrites it and the count saturates.
          w_top_nxt = r_top + PTR_ONE;
          if (r_cnt == CNT_FULL) begin
            w_err_nxt = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + CNT_ONE;
          end
        end
        SEL_RET: begin
          if (r_cnt != CNT_ZERO) begin
            w_pc_nxt  = align_f(w_ras_top);
            w_top_nxt = r_top - PTR_ONE;
            w_cnt_nxt = r_cnt - CNT_ONE;
          end else begin
            w_pc_nxt  = align_f(F);
            w_err_nxt = 1'b1;
          end
        end
        SEL_EXC: begin
          w_epc_nxt = w_pc_inc;
          w_pc_nxt  = align_f(EXC_VECTOR);
        end
        SEL_ERET: w_pc_nxt = align_f(r_epc);
        SEL_HOLD: w_pc_nxt = r_pc;
        default:  w_pc_nxt = r_pc;
      endcase
    end else begin
      w_pc_nxt = r_pc;
    end
  end

  // Control state: PC, EPC, RAS pointer/count and sticky error flag.
  always_ff @(negedge clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_pc  <= RESET_ADDR;
      r_epc <= {WIDTH{1'b0}};
      r_top <= PTR_ZERO;
      r_cnt <= CNT_ZERO;
      r_err <= 1'b0;
    end else begin
      r_pc  <= w_pc_nxt;
      r_epc <= w_epc_nxt;
      r_top <= w_top_nxt;
      r_cnt <= w_cnt_nxt;
      r_err <= w_err_nxt;
    end
  end

  // RAS storage; contents are meaningless while the count says empty, so no reset.
  always_ff @(negedge clk) begin
    if (w_push) begin
      r_ras[w_top_nxt] <= w_pc_inc;
    end else begin
      r_ras[w_top_nxt] <= r_ras[w_top_nxt];
    end
  end

  assign PC        = r_pc;
  assign EPC       = r_epc;
  assign ras_empty = (r_cnt == CNT_ZERO);
  assign ras_full  = (r_cnt == CNT_FULL);
  assign ras_err   = r_err;

endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised program-counter generator for the multi-cycle ARMv7-style CPU. It is the next generation of the single-width PC register and replaces it in the fetch stage. It selects the next PC from sequential, branch, jump, call/return and exception sources. A circular return-address stack (RAS) and an exception PC (EPC) register provide call/return and exception-return targets without register-file reads.

## Interface
Parameters:
- WIDTH, 32: address width in bits.
- RESET_ADDR, 0: PC value after reset.
- EXC_VECTOR, 32'h0000_0008: exception entry address, truncated to WIDTH.
- RAS_DEPTH, 4: number of RAS entries, a power of two and at least 2.

Ports:
- clk, input, 1: clock. State updates on the falling edge, matching the existing PC timing.
- Rst_n, input, 1: asynchronous, active-low reset.
- Write_PC, input, 1: update enable. When low, all state holds.
- PC_s, input, 3: next-PC select.
  - 000: sequential
  - 001: branch
  - 010: jump
  - 011: call
  - 100: return
  - 101: exception
  - 110: exception return
  - 111: hold
- B, input, WIDTH: branch target.
- F, input, WIDTH: jump, call, or fallback return target.
- PC, output, WIDTH: current PC.
- EPC, output, WIDTH: saved exception PC.
- ras_empty, output, 1: RAS holds 0 entries.
- ras_full, output, 1: RAS holds RAS_DEPTH entries.
- ras_err, output, 1: sticky flag; set on RAS overflow or underflow.

## Operation
- Reset (Rst_n low, asynchronous): PC=RESET_ADDR, EPC=0, RAS count=0, RAS top pointer=0, ras_empty=1, ras_full=0, ras_err=0. RAS entry contents are don't-care.
- Define PC_inc = (PC + 4) mod 2^WIDTH. Wrap-around from all-ones-minus-3 to 0 is legal and silent.
- Every target loaded into PC has bits [1:0] forced to 0. PC_inc keeps the alignment of PC.
- At a falling edge with Write_PC=1:
  - 000: PC <= PC_inc.
  - 001: PC <= B.
  - 010: PC <= F.
  - 011 call: PC <= F; push PC_inc onto the RAS.
  - 100 return, RAS non-empty: PC <= top entry; pop.
  - 100 return, RAS empty: PC <= F; no pop; set ras_err.
  - 101 exception: EPC <= PC_inc; PC <= EXC_VECTOR. The RAS is unchanged.
  - 110 exception return: PC <= EPC. EPC is unchanged.
  - 111: PC holds; no other state changes.
- RAS is circular, with the top pointer incremented on push and decremented on pop, modulo RAS_DEPTH.
  - Push when full: overwrite the oldest entry, count stays RAS_DEPTH, set ras_err.
  - Push when not full: count increments.
  - Pop: count decrements.
- ras_empty and ras_full are decoded from the registered count, so they are valid in the same half-cycle as PC.
- ras_err clears only on reset.
- Write_PC=0 with any PC_s: no change to PC, EPC, RAS, or ras_err.

## Timing
- Single-edge update. The new PC, EPC, RAS state and flags are visible immediately after the falling edge at which Write_PC=1 was sampled. There is no added latency.
- PC_s, B and F must be stable around the falling edge. They are sampled only at that edge.
- Call followed immediately by return (consecutive enabled edges) returns to the call's PC_inc.
- Reset asserted mid-operation, including between a push and a pop, fully discards RAS contents. The first enabled edge after release uses PC=RESET_ADDR.
- Reset release is asynchronous. The first update occurs at the first falling edge with Rst_n high.

## Test plan
- Reset and sequential:
  - Apply Rst_n=0: PC=0, ras_empty=1, ras_err=0.
  - Release reset, then apply 3 edges with PC_s=000: PC = 4, 8, 12.
  - With Write_PC=0: PC stays at 12.
- Branch, jump and alignment:
  - PC_s=001 with B=32'h0000_0103: PC=32'h0000_0100.
  - Then PC_s=010 with F=32'h0000_2000: PC=32'h0000_2000.
  - Then PC_s=111: PC stays at 32'h0000_2000.
- Nested calls and returns, RAS_DEPTH=4:
  - From PC=32'h100, call F=32'h200, then call F=32'h300: ras_empty=0.
  - Return: PC=32'h204. Return again: PC=32'h104, ras_empty=1, ras_err=0.
- Overflow and underflow:
  - 5 calls from PCs 0x10, 0x20, 0x30, 0x40, 0x50: ras_full=1, ras_err=1.
  - 4 returns: PC = 0x54, 0x44, 0x34, 0x24.
  - 5th return with F=32'h0000_0800: PC=32'h800, ras_err stays 1.
- Exception round trip:
  - At PC=32'h0000_0040, PC_s=101: PC=32'h0000_0008, EPC=32'h0000_0044, RAS unchanged.
  - 2 sequential edges, then PC_s=110: PC=32'h0000_0044.
- Wrap-around and reset mid-operation:
  - PC=32'hFFFF_FFFC with PC_s=000: PC=0.
  - Call 2 times, then pulse Rst_n low between clock edges: PC=RESET_ADDR, ras_empty=1, ras_err=0 immediately.
